oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma_pkg.sv | 25 ++
 rtl/oam_dma.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/oam_dma_pkg.sv
// Shared widths, default addresses and FSM state type for the OAM DMA engine.
package oam_dma_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned REG_WIDTH  = 8;
  localparam int unsigned IDX_WIDTH  = 8;

  localparam logic [ADDR_WIDTH-1:0] DEF_DMA_REG_ADDR  = 16'h4014;
  localparam logic [ADDR_WIDTH-1:0] DEF_OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } oam_dma_state_t;

  // Source address never leaves the selected page.
  function automatic logic [ADDR_WIDTH-1:0] src_addr(input logic [REG_WIDTH-1:0] page,
                                                     input logic [IDX_WIDTH-1:0] idx);
    return ADDR_WIDTH'({page, idx});
  endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA: copies one 256-byte CPU page to the OAM data port while stalling the CPU.
// Optional build macro OAM_DMA_ALIGN_EN adds a parity-dependent extra alignment cycle.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = DEF_DMA_REG_ADDR,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_din,
  input  logic                  cpu_we,
  output logic                  rdy,
  output logic                  dma_active,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [REG_WIDTH-1:0]  bus_dout,
  input  logic [REG_WIDTH-1:0]  bus_din,
  output logic                  bus_we,
  output logic                  done
);

  oam_dma_state_t        state_q, state_d;
  logic [REG_WIDTH-1:0]  page_q, page_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [REG_WIDTH-1:0]  latch_q, latch_d;
  logic                  rdy_q, rdy_d;
  logic                  active_q, active_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  trigger_c;

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;
  logic align_wait_q, align_wait_d;

  // Free-running cycle parity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q     <= 1'b0;
      align_wait_q <= 1'b0;
    end else begin
      parity_q     <= ~parity_q;
      align_wait_q <= align_wait_d;
    end
  end
`endif

  assign trigger_c = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      latch_q  <= '0;
      rdy_q    <= 1'b1;
      active_q <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      latch_q  <= latch_d;
      rdy_q    <= rdy_d;
      active_q <= active_d;
      we_q     <= we_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
`ifdef OAM_DMA_ALIGN_EN
    align_wait_d = align_wait_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          state_d = ST_ALIGN;
          page_d  = cpu_din;
          idx_d   = '0;
`ifdef OAM_DMA_ALIGN_EN
          // Parity after this edge is the inverse of the current one.
          align_wait_d = ~parity_q;
`endif
        end
      end
      ST_ALIGN: begin
`ifdef OAM_DMA_ALIGN_EN
        if (align_wait_q) begin
          align_wait_d = 1'b0;
        end else begin
          state_d = ST_READ;
        end
`else
        state_d = ST_READ;
`endif
      end
      ST_READ: begin
        latch_d = bus_din;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d   = idx_q + IDX_WIDTH'(1);
        state_d = (idx_q == '1) ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rdy_d    = (state_d == ST_IDLE);
    active_d = (state_d != ST_IDLE);
    we_d     = (state_d == ST_WRITE);
    done_d   = (state_d == ST_DONE);
    addr_d   = '0;
    if (state_d == ST_READ) begin
      addr_d = src_addr(page_d, idx_d);
    end else if (state_d == ST_WRITE) begin
      addr_d = OAM_DATA_ADDR;
    end
  end

  assign rdy        = rdy_q;
  assign dma_active = active_q;
  assign bus_we     = we_q;
  assign done       = done_q;
  assign bus_addr   = addr_q;
  assign bus_dout   = latch_q;

endmodule
